fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FIFO write port, range 2..8.
REQ-002 Parameter DATASIZE, default 8: data word width, equal to the FIFO DATASIZE.
REQ-003 Parameter MAX_BURST, default 4: maximum words accepted per grant tenure, range 1..16.
REQ-004 wclk  input  1  the single clock; all state changes on the rising edge.
REQ-005 wreset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  NUM_REQ  per-requester write request; a requester holds it high while it has a word.
REQ-007 req_data  input  NUM_REQ*DATASIZE  packed words; requester i uses bits [i*DATASIZE +: DATASIZE].
REQ-008 wfull  input  1  FIFO full flag from the write domain.
REQ-009 gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
REQ-010 winc  output  1  FIFO write strobe.
REQ-011 wdata  output  DATASIZE  FIFO write data.
REQ-012 busy  output  1  high in BURST state.

Function
REQ-013 The block SHALL have two states: IDLE (gnt zero) and BURST (gnt one-hot on owner).
REQ-014 Accept SHALL be defined as BURST & req[owner] & ~wfull, evaluated combinationally in the same cycle.
REQ-015 winc SHALL equal accept, and wdata SHALL equal the owner's req_data slice, with zero latency.
REQ-016 wdata SHALL be all zero when not in BURST.
REQ-017 IDLE to BURST: when any req bit is high, the next edge SHALL grant the first requesting index searching from last_owner+1 upward with wraparound.
REQ-018 The arbitration SHALL be round-robin, with last_owner updated on every grant. The previous owner has the lowest priority.
REQ-019 burst_cnt SHALL clear on each new grant and increment on each accept.
REQ-020 Tenure SHALL end at an edge when either condition holds: (a) req[owner] is low, or (b) an accept occurs with burst_cnt == MAX_BURST-1.
REQ-021 At tenure end, if any other requester's req is high, the arbiter SHALL hand off directly to the next round-robin index with no idle cycle.
REQ-022 At tenure end, the old owner SHALL be eligible again only if no other requester is pending.
REQ-023 At tenure end with no request pending, the block SHALL return to IDLE.
REQ-024 While wfull is high, the block SHALL hold state, owner and burst_cnt. No accept SHALL occur and no overflow write SHALL be issued.
REQ-025 A wfull stall SHALL NOT end a tenure; only REQ-020 SHALL end it.
REQ-026 Requests from non-owners SHALL be ignored until re-arbitration and SHALL never produce winc.
REQ-027 At most one word SHALL be written per cycle.
REQ-028 burst_cnt SHALL be ceil(log2(MAX_BURST+1)) bits wide. The MAX_BURST=1 case SHALL re-arbitrate after every accept.

Reset
REQ-029 On wreset_n low, the block SHALL immediately enter IDLE with gnt=0, winc=0, wdata=0, busy=0, burst_cnt=0, last_owner=NUM_REQ-1, regardless of clock.
REQ-030 Reset mid-burst SHALL abort the tenure; the partially sent burst SHALL not be resumed.
REQ-031 The first grant after reset deassertion SHALL be requester 0 if it is requesting.

Structure
REQ-032 State encoding (IDLE/BURST) and the round-robin search function SHALL live in a shared package with the FIFO parameter defaults.
REQ-033 The round-robin pick SHALL be one sub-module, rr_pick: a combinational request vector plus last index producing a one-hot result and a valid flag.
REQ-034 The block SHALL connect directly to the FIFO's wdata, winc and wfull with no additional registers.

Verification
REQ-035 Requesters 0 and 2 constantly high, wfull=0, MAX_BURST=4, word values 8'hA0.. and 8'hC0..:
- Expect 4 winc from requester 0, then 4 from requester 2, then requester 0 again.
- Handoffs SHALL have no gap cycles.
REQ-036 Only requester 1 is high for 10 cycles:
- Expect a 4-word burst, then re-grant of requester 1 with no gap, giving 10 consecutive winc.
REQ-037 Requester 3 is granted, then wfull goes high for 3 cycles after the 2nd word:
- winc SHALL stay 0 for those 3 cycles.
- burst_cnt SHALL hold at 2.
- Exactly 2 more words SHALL follow before the tenure ends.
REQ-038 Owner 0 drops req after 1 word while requester 1 is pending:
- gnt SHALL move to 4'b0010 on the next edge.
REQ-039 wreset_n is pulsed low mid-burst, asynchronously between edges:
- gnt, winc and wdata SHALL go to 0 immediately.
- After release with all req high, the first grant SHALL be 4'b0001.
REQ-040 Randomized scenario with 4 requesters, random wfull and a scoreboard:
- No winc while wfull is high.
- Per-requester word order SHALL be preserved.
- No requester SHALL starve beyond (NUM_REQ-1)*MAX_BURST accepted words.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: shared state encoding, FIFO defaults and round-robin search helpers
package fifo_write_arbiter_pkg;

   localparam int FIFO_DATASIZE  = 8;
   localparam int FIFO_NUM_REQ   = 4;
   localparam int FIFO_MAX_BURST = 4;
   localparam int RR_MAX         = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // One-hot of the first set req bit after 'last', wrapping at n; 'last' itself is checked last.
   function automatic logic [RR_MAX-1:0] rr_search(input logic [RR_MAX-1:0] req,
                                                   input logic [2:0] last,
                                                   input int n);
      logic [RR_MAX-1:0] oh;
      logic [3:0]        idx;
      oh = '0;
      for (int k = RR_MAX; k >= 1; k--) begin
         if (k <= n) begin
            idx = 4'(last) + 4'(k);
            if (idx >= 4'(n)) idx = idx - 4'(n);
            if (req[idx[2:0]]) oh = RR_MAX'(1) << idx[2:0];
         end
      end
      return oh;
   endfunction

   function automatic logic [2:0] oh_to_idx(input logic [RR_MAX-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < RR_MAX; i++)
         if (oh[i]) idx = idx | 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the next requester after 'last'
module rr_pick
   import fifo_write_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  pick,
   output logic          valid
);

   logic [RR_MAX-1:0] full;

   assign full  = rr_search(RR_MAX'(req), 3'(last), N);
   assign pick  = full[N-1:0];
   assign valid = |full;

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = FIFO_NUM_REQ,
   parameter int DATASIZE  = FIFO_DATASIZE,
   parameter int MAX_BURST = FIFO_MAX_BURST
) (
   input  logic                         wclk,
   input  logic                         wreset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATASIZE-1:0]  req_data,
   input  logic                         wfull,
   output logic [NUM_REQ-1:0]           gnt,
   output logic                         winc,
   output logic [DATASIZE-1:0]          wdata,
   output logic                         busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   state_t             state, state_next;
   logic [IW-1:0]      last_owner, last_next;
   logic [CW-1:0]      burst_cnt, cnt_next;
   logic [NUM_REQ-1:0] gnt_next, pick;
   logic               pick_valid, accept, tenure_end;

   rr_pick #(.N(NUM_REQ)) u_rr_pick (
      .req  (req),
      .last (last_owner),
      .pick (pick),
      .valid(pick_valid)
   );

   // last_owner is updated on every grant, so during BURST it is the current owner
   assign busy       = state == BURST;
   assign accept     = busy & req[last_owner] & ~wfull;
   assign tenure_end = busy & (~req[last_owner] | (accept & (burst_cnt == CW'(MAX_BURST - 1))));
   assign winc       = accept;
   assign wdata      = busy ? req_data[last_owner*DATASIZE +: DATASIZE] : '0;

   // Next state: arbitrate when idle or at tenure end, otherwise count accepted words
   always_comb begin
      state_next = state;
      gnt_next   = gnt;
      last_next  = last_owner;
      cnt_next   = burst_cnt;
      if (state == IDLE || tenure_end) begin
         state_next = pick_valid ? BURST : IDLE;
         gnt_next   = pick;
         last_next  = pick_valid ? IW'(oh_to_idx(RR_MAX'(pick))) : last_owner;
         cnt_next   = '0;
      end else if (accept) begin
         cnt_next   = burst_cnt + CW'(1);
      end
   end

   // State register; reset aborts any tenure and makes requester 0 first in line
   always_ff @(posedge wclk or negedge wreset_n) begin
      if (!wreset_n) begin
         state      <= IDLE;
         gnt        <= '0;
         last_owner <= IW'(NUM_REQ - 1);
         burst_cnt  <= '0;
      end else begin
         state      <= state_next;
         gnt        <= gnt_next;
         last_owner <= last_next;
         burst_cnt  <= cnt_next;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: scoreboard-based bench for the round-robin FIFO write arbiter
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic           wclk = 1'b0;
   logic           wreset_n = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic           wfull = 1'b0;
   logic [N-1:0]   gnt;
   logic           winc;
   logic [W-1:0]   wdata;
   logic           busy;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [N-1:0] g;
      logic [W-1:0] d;
   } wr_t;

   logic [W-1:0] src_q[N][$];
   logic [W-1:0] sb_q[N][$];
   wr_t          exp_q[$];
   logic         full_v = 1'b0;

   logic         obs_winc, obs_wfull, obs_busy;
   logic [W-1:0] obs_wdata;
   logic [N-1:0] obs_gnt, obs_req;
   logic [2:0]   obs_cnt;
   int           obs_owner;

   always #5 wclk = ~wclk;

   fifo_write_arbiter #(.NUM_REQ(N), .DATASIZE(W), .MAX_BURST(MB)) dut (
      .wclk    (wclk),
      .wreset_n(wreset_n),
      .req     (req),
      .req_data(req_data),
      .wfull   (wfull),
      .gnt     (gnt),
      .winc    (winc),
      .wdata   (wdata),
      .busy    (busy)
   );

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         sb_q[i].delete();
      end
      exp_q.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req[i] = src_q[i].size() != 0;
         req_data[i*W +: W] = req[i] ? src_q[i][0] : '0;
      end
      wfull = full_v;
   endtask

   task automatic cycle();
      @(negedge wclk);
      drive();
      #1;
      obs_winc  = winc;
      obs_wdata = wdata;
      obs_gnt   = gnt;
      obs_req   = req;
      obs_wfull = wfull;
      obs_busy  = busy;
      obs_cnt   = dut.burst_cnt;
      obs_owner = -1;
      for (int i = 0; i < N; i++)
         if (gnt[i]) obs_owner = i;
      if (obs_winc && obs_owner >= 0 && src_q[obs_owner].size() != 0)
         void'(src_q[obs_owner].pop_front());
   endtask

   task automatic do_reset();
      @(negedge wclk);
      clear_src();
      full_v = 1'b0;
      drive();
      wreset_n = 1'b0;
      @(negedge wclk);
      wreset_n = 1'b1;
   endtask

   task automatic test_reset();
      req = '1;
      req_data = '1;
      #2 wreset_n = 1'b0;
      #1;
      tests++; if (gnt !== '0) begin fails++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
      tests++; if (winc !== 1'b0) begin fails++; $display("FAIL reset_winc: got %b expected 0", winc); end
      tests++; if (wdata !== '0) begin fails++; $display("FAIL reset_wdata: got %h expected 00", wdata); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (dut.last_owner !== 2'd3) begin fails++; $display("FAIL reset_last_owner: got %0d expected 3", dut.last_owner); end
      tests++; if (dut.burst_cnt !== 3'd0) begin fails++; $display("FAIL reset_burst_cnt: got %0d expected 0", dut.burst_cnt); end
      @(posedge wclk);
      #1;
      tests++; if (gnt !== '0 || busy !== 1'b0) begin fails++; $display("FAIL reset_hold: gnt %b busy %b expected 0 0", gnt, busy); end
      do_reset();
   endtask

   task automatic run_expected(input string name, input int budget);
      bit started = 0;
      wr_t e;
      for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
         cycle();
         if (obs_winc) begin
            started = 1;
            e = exp_q.pop_front();
            tests++;
            if (obs_gnt !== e.g || obs_wdata !== e.d) begin
               fails++;
               $display("FAIL %s_word: got gnt %b data %h expected gnt %b data %h", name, obs_gnt, obs_wdata, e.g, e.d);
            end
         end else if (started) begin
            tests++; fails++;
            $display("FAIL %s_gap: got winc 0 expected 1 (%0d words left)", name, exp_q.size());
         end
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      wr_t e;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         src_q[0].push_back(8'hA0 + 8'(k));
         src_q[2].push_back(8'hC0 + 8'(k));
      end
      for (int b = 0; b < 4; b++)
         for (int j = 0; j < MB; j++) begin
            e.g = (b % 2 == 0) ? 4'b0001 : 4'b0100;
            e.d = ((b % 2 == 0) ? 8'hA0 : 8'hC0) + 8'((b / 2) * MB + j);
            exp_q.push_back(e);
         end
      run_expected("rr", 40);
   endtask

   task automatic test_single();
      wr_t e;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         src_q[1].push_back(8'h10 + 8'(k));
         e.g = 4'b0010;
         e.d = 8'h10 + 8'(k);
         exp_q.push_back(e);
      end
      run_expected("single", 30);
      cycle();
      tests++; if (obs_winc !== 1'b0) begin fails++; $display("FAIL single_after: got winc %b expected 0", obs_winc); end
      cycle();
      tests++; if (obs_busy !== 1'b0 || obs_gnt !== '0) begin fails++; $display("FAIL single_idle: got busy %b gnt %b expected 0 0000", obs_busy, obs_gnt); end
   endtask

   task automatic test_wfull();
      int n = 0;
      do_reset();
      for (int k = 0; k < 8; k++) src_q[3].push_back(8'h30 + 8'(k));
      for (int c = 0; c < 10 && n < 2; c++) begin
         cycle();
         if (obs_winc) begin
            tests++;
            if (obs_wdata !== 8'h30 + 8'(n) || obs_gnt !== 4'b1000) begin
               fails++;
               $display("FAIL wfull_pre: got gnt %b data %h expected 1000 %h", obs_gnt, obs_wdata, 8'h30 + 8'(n));
            end
            n++;
         end
      end
      tests++; if (n != 2) begin fails++; $display("FAIL wfull_start: got %0d words expected 2", n); end
      full_v = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle();
         tests++; if (obs_winc !== 1'b0) begin fails++; $display("FAIL wfull_winc: got %b expected 0", obs_winc); end
         tests++; if (obs_cnt !== 3'd2 || obs_gnt !== 4'b1000) begin fails++; $display("FAIL wfull_hold: got cnt %0d gnt %b expected 2 1000", obs_cnt, obs_gnt); end
      end
      full_v = 1'b0;
      for (int j = 0; j < 2; j++) begin
         cycle();
         tests++;
         if (obs_winc !== 1'b1 || obs_wdata !== 8'h32 + 8'(j) || obs_gnt !== 4'b1000) begin
            fails++;
            $display("FAIL wfull_resume: got winc %b data %h gnt %b expected 1 %h 1000", obs_winc, obs_wdata, obs_gnt, 8'h32 + 8'(j));
         end
      end
      cycle();
      tests++;
      if (obs_cnt !== 3'd0 || obs_winc !== 1'b1 || obs_wdata !== 8'h34) begin
         fails++;
         $display("FAIL wfull_end: got cnt %0d winc %b data %h expected 0 1 34", obs_cnt, obs_winc, obs_wdata);
      end
   endtask

   task automatic test_drop();
      do_reset();
      src_q[0].push_back(8'h50);
      for (int k = 0; k < 3; k++) src_q[1].push_back(8'h60 + 8'(k));
      cycle();
      cycle();
      tests++; if (obs_winc !== 1'b1 || obs_wdata !== 8'h50 || obs_gnt !== 4'b0001) begin fails++; $display("FAIL drop_first: got winc %b data %h gnt %b expected 1 50 0001", obs_winc, obs_wdata, obs_gnt); end
      cycle();
      tests++; if (obs_winc !== 1'b0 || obs_gnt !== 4'b0001) begin fails++; $display("FAIL drop_low: got winc %b gnt %b expected 0 0001", obs_winc, obs_gnt); end
      cycle();
      tests++; if (obs_gnt !== 4'b0010 || obs_winc !== 1'b1 || obs_wdata !== 8'h60) begin fails++; $display("FAIL drop_handoff: got gnt %b winc %b data %h expected 0010 1 60", obs_gnt, obs_winc, obs_wdata); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 8; k++) src_q[2].push_back(8'h70 + 8'(k));
      cycle();
      cycle();
      cycle();
      tests++; if (obs_gnt !== 4'b0100 || obs_winc !== 1'b1) begin fails++; $display("FAIL arst_pre: got gnt %b winc %b expected 0100 1", obs_gnt, obs_winc); end
      #2 wreset_n = 1'b0;
      #1;
      tests++; if (gnt !== '0 || winc !== 1'b0 || wdata !== '0 || busy !== 1'b0) begin fails++; $display("FAIL arst_now: got gnt %b winc %b data %h busy %b expected 0000 0 00 0", gnt, winc, wdata, busy); end
      @(negedge wclk);
      clear_src();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 4; k++) src_q[i].push_back(8'h80 + 8'(i * 16 + k));
      drive();
      wreset_n = 1'b1;
      cycle();
      tests++; if (obs_gnt !== 4'b0001 || obs_winc !== 1'b1 || obs_wdata !== 8'h80) begin fails++; $display("FAIL arst_first: got gnt %b winc %b data %h expected 0001 1 80", obs_gnt, obs_winc, obs_wdata); end
   endtask

   task automatic test_random();
      int seq[N];
      int waits[N];
      logic [W-1:0] e;
      do_reset();
      for (int i = 0; i < N; i++) begin seq[i] = 0; waits[i] = 0; end
      for (int c = 0; c < 800; c++) begin
         if (c < 600) begin
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 3) == 0 && src_q[i].size() < 6) begin
                  e = {2'(i), 6'(seq[i])};
                  seq[i]++;
                  src_q[i].push_back(e);
                  sb_q[i].push_back(e);
               end
            full_v = $urandom_range(0, 3) == 0;
         end else begin
            full_v = 1'b0;
         end
         cycle();
         if (obs_winc) begin
            tests++;
            if (obs_wfull) begin fails++; $display("FAIL rnd_full: got winc 1 while wfull expected 0"); end
            tests++;
            if (obs_owner < 0 || sb_q[obs_owner].size() == 0) begin
               fails++;
               $display("FAIL rnd_unexpected: got winc with gnt %b expected no write", obs_gnt);
            end else begin
               e = sb_q[obs_owner].pop_front();
               if (obs_wdata !== e) begin fails++; $display("FAIL rnd_order: got %h expected %h from req %0d", obs_wdata, e, obs_owner); end
            end
            for (int i = 0; i < N; i++) begin
               if (i == obs_owner) waits[i] = 0;
               else if (obs_req[i]) waits[i]++;
               tests++;
               if (waits[i] > (N - 1) * MB) begin fails++; $display("FAIL rnd_starve: got %0d words waited by req %0d expected <= %0d", waits[i], i, (N - 1) * MB); end
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         tests++;
         if (sb_q[i].size() != 0) begin fails++; $display("FAIL rnd_drain: got %0d words left for req %0d expected 0", sb_q[i].size(), i); end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_wfull();
      test_drop();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1, "watchdog");
   end

endmodule
